// File: rtl/ssd_pkg.sv
// Shared seven-segment definitions: hex segment table, blank pattern, clog2 helper.
package ssd_pkg;

   localparam logic [7:0] BLANK_CATHODES = 8'hFF;

   // Active-low {a,b,c,d,e,f,g} patterns, entry 15 first so HEX_SEG[n] decodes nibble n.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'b0111000,  // F
      7'b0110000,  // E
      7'b1000010,  // d
      7'b0110001,  // C
      7'b1100000,  // b
      7'b0001000,  // A
      7'b0000100,  // 9
      7'b0000000,  // 8
      7'b0001111,  // 7
      7'b0100000,  // 6
      7'b0100100,  // 5
      7'b1001100,  // 4
      7'b0000110,  // 3
      7'b0010010,  // 2
      7'b1001111,  // 1
      7'b0000001   // 0
   };

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = 1; v < n; v = v << 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble + decimal point to active-low {Ca..Cg,Dp} pattern.
module ssd_hex_decode
   import ssd_pkg::*;
(
   input  logic [3:0] nibble,
   input  logic       dp,
   output logic [7:0] cathodes_c
);

   assign cathodes_c = {HEX_SEG[nibble], ~dp};

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scan controller with blanking, PWM dimming, guard
// cycles and frame-aligned double-buffered digit loading.
module ssd_scan_ctrl
   import ssd_pkg::*;
#(
   parameter  int unsigned NUM_DIGITS    = 4,
   parameter  int unsigned SCAN_DIV_LOG2 = 18,
   parameter  int unsigned BRIGHT_BITS   = 4,
   parameter  int unsigned GUARD         = 16,
   localparam int unsigned IDX_W         = (clog2(NUM_DIGITS) < 1) ? 1 : clog2(NUM_DIGITS)
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [4*NUM_DIGITS-1:0] Digits_In,
   input  logic [NUM_DIGITS-1:0]   Dp_In,
   input  logic                    Load,
   input  logic [NUM_DIGITS-1:0]   Digit_En,
   input  logic                    Blank_Lz,
   input  logic [BRIGHT_BITS-1:0]  Brightness,
   output logic [NUM_DIGITS-1:0]   An,
   output logic [7:0]              Cathodes,
   output logic [IDX_W-1:0]        Scan_Idx,
   output logic                    Frame_Done
);

   logic [SCAN_DIV_LOG2-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0]   disp_dig_q, disp_dig_d;
   logic [NUM_DIGITS-1:0][3:0]   pend_dig_q, pend_dig_d;
   logic [NUM_DIGITS-1:0]        disp_dp_q, disp_dp_d;
   logic [NUM_DIGITS-1:0]        pend_dp_q, pend_dp_d;
   logic                         pend_valid_q, pend_valid_d;
   logic [NUM_DIGITS-1:0]        an_q, an_d;
   logic [7:0]                   cath_q, cath_d;
   logic [IDX_W-1:0]             scan_idx_q, scan_idx_d;
   logic                         frame_done_q, frame_done_d;

   logic                         slot_end_c;
   logic                         frame_end_c;
   logic                         an_on_c;
   logic [NUM_DIGITS-1:0]        lz_blank_c;
   logic [7:0]                   dec_cath_c;

   ssd_hex_decode u_dec (
      .nibble     (disp_dig_q[idx_q]),
      .dp         (disp_dp_q[idx_q]),
      .cathodes_c (dec_cath_c)
   );

   // Leading-zero blanking: a digit is blank when it and every higher digit are zero.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      lz_blank_c = '0;
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
         zero_above    = zero_above && (disp_dig_q[d] == 4'h0);
         lz_blank_c[d] = Blank_Lz && zero_above && (d != 0);
      end
   end

   always_comb begin
      slot_end_c  = &cnt_q;
      frame_end_c = slot_end_c && (idx_q == IDX_W'(NUM_DIGITS - 1));

      cnt_d = cnt_q + SCAN_DIV_LOG2'(1);
      idx_d = idx_q;
      if (slot_end_c) idx_d = frame_end_c ? '0 : idx_q + IDX_W'(1);

      pend_dig_d   = pend_dig_q;
      pend_dp_d    = pend_dp_q;
      pend_valid_d = pend_valid_q;
      disp_dig_d   = disp_dig_q;
      disp_dp_d    = disp_dp_q;
      if (Load) begin
         pend_dig_d   = Digits_In;
         pend_dp_d    = Dp_In;
         pend_valid_d = 1'b1;
      end
      // Display only swaps at the frame boundary; a coincident Load bypasses pending.
      if (frame_end_c) begin
         if (Load) begin
            disp_dig_d = Digits_In;
            disp_dp_d  = Dp_In;
         end else if (pend_valid_q) begin
            disp_dig_d = pend_dig_q;
            disp_dp_d  = pend_dp_q;
         end
         pend_valid_d = 1'b0;
      end

      an_on_c = Digit_En[idx_q] && !lz_blank_c[idx_q]
                && (cnt_q >= SCAN_DIV_LOG2'(GUARD))
                && (cnt_q[SCAN_DIV_LOG2-1 -: BRIGHT_BITS] <= Brightness);
      an_d         = an_on_c ? ~(NUM_DIGITS'(1) << idx_q) : '1;
      cath_d       = an_on_c ? dec_cath_c : BLANK_CATHODES;
      scan_idx_d   = idx_q;
      frame_done_d = frame_end_c;
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         cnt_q        <= '0;
         idx_q        <= '0;
         disp_dig_q   <= '0;
         disp_dp_q    <= '0;
         pend_dig_q   <= '0;
         pend_dp_q    <= '0;
         pend_valid_q <= 1'b0;
         an_q         <= '1;
         cath_q       <= BLANK_CATHODES;
         scan_idx_q   <= '0;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         disp_dig_q   <= disp_dig_d;
         disp_dp_q    <= disp_dp_d;
         pend_dig_q   <= pend_dig_d;
         pend_dp_q    <= pend_dp_d;
         pend_valid_q <= pend_valid_d;
         an_q         <= an_d;
         cath_q       <= cath_d;
         scan_idx_q   <= scan_idx_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign An         = an_q;
   assign Cathodes   = cath_q;
   assign Scan_Idx   = scan_idx_q;
   assign Frame_Done = frame_done_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl: 4 digits, 16-cycle slots, 64-cycle frames.
module tb_ssd_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] digits_in;
   logic [3:0]  dp_in;
   logic        load;
   logic [3:0]  digit_en;
   logic        blank_lz;
   logic [1:0]  brightness;
   logic [3:0]  an;
   logic [7:0]  cathodes;
   logic [1:0]  scan_idx;
   logic        frame_done;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   ssd_scan_ctrl #(
      .NUM_DIGITS    (4),
      .SCAN_DIV_LOG2 (4),
      .BRIGHT_BITS   (2),
      .GUARD         (2)
   ) dut (
      .Clk        (clk),
      .Reset      (reset_n),
      .Digits_In  (digits_in),
      .Dp_In      (dp_in),
      .Load       (load),
      .Digit_En   (digit_en),
      .Blank_Lz   (blank_lz),
      .Brightness (brightness),
      .An         (an),
      .Cathodes   (cathodes),
      .Scan_Idx   (scan_idx),
      .Frame_Done (frame_done)
   );

   always #5 clk = ~clk;

   // cyc is the state cycle since reset release; outputs seen now reflect cyc-1.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         cyc = cyc + 1;
      end
   endtask

   task automatic goto(input int t);
      while (cyc < t) tick(1);
   endtask

   task automatic load_word(input logic [15:0] w, input logic [3:0] dp);
      digits_in = w;
      dp_in     = dp;
      load      = 1'b1;
      tick(1);
      load      = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      tick(2);
      checks++;
      if (an !== 4'hF || cathodes !== 8'hFF || scan_idx !== 2'd0 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL reset_state an=%b cath=%h idx=%0d fd=%b exp an=1111 cath=ff idx=0 fd=0",
                  an, cathodes, scan_idx, frame_done);
      end
      reset_n = 1'b1;
      cyc     = 0;
   endtask

   task automatic test_double_buffer;
      int pulses;
      goto(5);
      load_word(16'h1234, 4'b0000);
      goto(64);
      checks++;
      if (frame_done !== 1'b1) begin
         failures++;
         $display("FAIL db_frame_done_64 got=%b exp=1", frame_done);
      end
      checks++;
      if (an !== 4'b0111 || cathodes !== 8'h03) begin
         failures++;
         $display("FAIL db_old_display_c63 an=%b cath=%h exp an=0111 cath=03", an, cathodes);
      end
      tick(1);
      checks++;
      if (frame_done !== 1'b0 || an !== 4'hF || cathodes !== 8'hFF) begin
         failures++;
         $display("FAIL db_guard_c64 fd=%b an=%b cath=%h exp fd=0 an=1111 cath=ff",
                  frame_done, an, cathodes);
      end
      goto(67);
      checks++;
      if (an !== 4'b1110 || cathodes !== 8'h99) begin
         failures++;
         $display("FAIL db_new_digit0 an=%b cath=%h exp an=1110 cath=99", an, cathodes);
      end
      goto(83);
      checks++;
      if (an !== 4'b1101 || cathodes !== 8'h0D || scan_idx !== 2'd1) begin
         failures++;
         $display("FAIL db_new_digit1 an=%b cath=%h idx=%0d exp an=1101 cath=0d idx=1",
                  an, cathodes, scan_idx);
      end
      pulses = 0;
      repeat (64) begin
         tick(1);
         if (frame_done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1) begin
         failures++;
         $display("FAIL db_pulses_per_frame got=%0d exp=1", pulses);
      end
   endtask

   task automatic test_brightness;
      logic [3:0] exp_an;
      logic [7:0] exp_ca;
      int         bad;
      goto(150);
      brightness = 2'b01;
      load_word(16'h8888, 4'b0000);
      bad = 0;
      for (int k = 0; k < 64; k++) begin
         goto(192 + k + 1);
         if ((k % 16) >= 2 && (k % 16) <= 7) begin
            exp_an = ~(4'b0001 << (k / 16));
            exp_ca = 8'h01;
         end else begin
            exp_an = 4'hF;
            exp_ca = 8'hFF;
         end
         checks++;
         if (an !== exp_an || cathodes !== exp_ca) begin
            failures++;
            bad++;
            if (bad <= 4)
               $display("FAIL pwm_k%0d an=%b cath=%h exp an=%b cath=%h",
                        k, an, cathodes, exp_an, exp_ca);
         end
      end
   endtask

   task automatic test_lz_blank;
      logic [3:0] exp_an [4];
      logic [7:0] exp_ca [4];
      goto(260);
      brightness = 2'b11;
      blank_lz   = 1'b1;
      load_word(16'h0050, 4'b0000);
      exp_an = '{4'b1110, 4'b1101, 4'hF, 4'hF};
      exp_ca = '{8'h03, 8'h49, 8'hFF, 8'hFF};
      for (int s = 0; s < 4; s++) begin
         goto(320 + 16 * s + 3);
         checks++;
         if (an !== exp_an[s] || cathodes !== exp_ca[s]) begin
            failures++;
            $display("FAIL lz_0050_slot%0d an=%b cath=%h exp an=%b cath=%h",
                     s, an, cathodes, exp_an[s], exp_ca[s]);
         end
      end
      goto(372);
      load_word(16'h0000, 4'b0000);
      exp_an = '{4'b1110, 4'hF, 4'hF, 4'hF};
      exp_ca = '{8'h03, 8'hFF, 8'hFF, 8'hFF};
      for (int s = 0; s < 4; s++) begin
         goto(384 + 16 * s + 3);
         checks++;
         if (an !== exp_an[s] || cathodes !== exp_ca[s]) begin
            failures++;
            $display("FAIL lz_0000_slot%0d an=%b cath=%h exp an=%b cath=%h",
                     s, an, cathodes, exp_an[s], exp_ca[s]);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [3:0] exp_an;
      goto(450);
      blank_lz = 1'b0;
      load_word(16'hAAAA, 4'b0000);
      goto(460);
      load_word(16'hBBBB, 4'b0000);
      for (int s = 0; s < 4; s++) begin
         goto(512 + 16 * s + 3);
         exp_an = ~(4'b0001 << s);
         checks++;
         if (an !== exp_an || cathodes !== 8'hC1) begin
            failures++;
            $display("FAIL b2b_last_wins_slot%0d an=%b cath=%h exp an=%b cath=c1",
                     s, an, cathodes, exp_an);
         end
      end
      goto(570);
      load_word(16'hDDDD, 4'b0000);
      goto(575);
      load_word(16'hCCCC, 4'b0000);
      checks++;
      if (frame_done !== 1'b1 || an !== 4'b0111 || cathodes !== 8'hC1) begin
         failures++;
         $display("FAIL b2b_boundary_c575 fd=%b an=%b cath=%h exp fd=1 an=0111 cath=c1",
                  frame_done, an, cathodes);
      end
      for (int s = 0; s < 4; s++) begin
         goto(576 + 16 * s + 3);
         exp_an = ~(4'b0001 << s);
         checks++;
         if (an !== exp_an || cathodes !== 8'h63) begin
            failures++;
            $display("FAIL b2b_coincident_slot%0d an=%b cath=%h exp an=%b cath=63",
                     s, an, cathodes, exp_an);
         end
      end
      goto(643);
      checks++;
      if (an !== 4'b1110 || cathodes !== 8'h63) begin
         failures++;
         $display("FAIL b2b_pending_cleared an=%b cath=%h exp an=1110 cath=63", an, cathodes);
      end
   endtask

   task automatic test_digit_en;
      logic [3:0] exp_an [4];
      logic [7:0] exp_ca [4];
      goto(650);
      digit_en = 4'b0101;
      load_word(16'h1234, 4'b0001);
      exp_an = '{4'b1110, 4'hF, 4'b1011, 4'hF};
      exp_ca = '{8'h98, 8'hFF, 8'h25, 8'hFF};
      for (int s = 0; s < 4; s++) begin
         goto(704 + 16 * s + 3);
         checks++;
         if (an !== exp_an[s] || cathodes !== exp_ca[s]) begin
            failures++;
            $display("FAIL en_dp_slot%0d an=%b cath=%h exp an=%b cath=%h",
                     s, an, cathodes, exp_an[s], exp_ca[s]);
         end
      end
   endtask

   task automatic test_mid_frame_reset;
      int pulses;
      goto(809);
      reset_n = 1'b0;
      tick(1);
      checks++;
      if (an !== 4'hF || cathodes !== 8'hFF || scan_idx !== 2'd0 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL midreset_state an=%b cath=%h idx=%0d fd=%b exp an=1111 cath=ff idx=0 fd=0",
                  an, cathodes, scan_idx, frame_done);
      end
      reset_n = 1'b1;
      cyc     = 0;
      goto(3);
      checks++;
      if (an !== 4'b1110 || cathodes !== 8'h03 || scan_idx !== 2'd0) begin
         failures++;
         $display("FAIL midreset_restart an=%b cath=%h idx=%0d exp an=1110 cath=03 idx=0",
                  an, cathodes, scan_idx);
      end
      pulses = 0;
      while (cyc < 63) begin
         tick(1);
         if (frame_done === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         failures++;
         $display("FAIL midreset_early_frame_done got=%0d exp=0", pulses);
      end
      tick(1);
      checks++;
      if (frame_done !== 1'b1) begin
         failures++;
         $display("FAIL midreset_frame_done_64 got=%b exp=1", frame_done);
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      digits_in  = 16'h0000;
      dp_in      = 4'b0000;
      load       = 1'b0;
      digit_en   = 4'hF;
      blank_lz   = 1'b0;
      brightness = 2'b11;
      test_reset;
      test_double_buffer;
      test_brightness;
      test_lz_blank;
      test_back_to_back;
      test_digit_en;
      test_mid_frame_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Parametrised seven-segment display scan controller. Drives N common-anode digits from a packed hex bus and replaces the fixed 4-digit, DIV_CLK-tapped scanning in the board top level.
Adds per-digit enable, leading-zero blanking, PWM brightness, anti-ghosting guard cycles, and tear-free double-buffered loading with a frame-done strobe.
Sits between the game core (score, debug values) and the board's An/Ca..Cg/Dp pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (>=1)
SCAN_DIV_LOG2, 18, log2 of Clk cycles per digit slot (2^18 at 100 MHz = 381 Hz per digit)
BRIGHT_BITS, 4, width of the brightness control (must be <= SCAN_DIV_LOG2)
GUARD, 16, cycles at the start of each slot with all anodes off (must be < 2^SCAN_DIV_LOG2)

Ports:
Clk  in  1  system clock
Reset  in  1  synchronous, active-low reset: asserted when 0 at a Clk posedge
Digits_In  in  4*NUM_DIGITS  hex nibbles; nibble 0 is the rightmost digit
Dp_In  in  NUM_DIGITS  decimal point per digit, active-high
Load  in  1  capture Digits_In/Dp_In into the pending buffer
Digit_En  in  NUM_DIGITS  live per-digit enable; 0 blanks the digit
Blank_Lz  in  1  live leading-zero blanking enable
Brightness  in  BRIGHT_BITS  live PWM level; all-ones is maximum
An  out  NUM_DIGITS  anodes, active-low, registered
Cathodes  out  8  {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}, active-low, registered
Scan_Idx  out  clog2(NUM_DIGITS) (min 1)  digit currently being scanned
Frame_Done  out  1  one-cycle pulse per completed frame

Behaviour:
- Reset (Reset=0 at posedge):
  - prescaler cnt=0, idx=0.
  - display and pending buffers = 0; pending_valid=0.
  - An=all 1, Cathodes=8'hFF, Scan_Idx=0, Frame_Done=0.
  - Reset mid-frame takes effect on the next edge with no partial-slot completion.
- Prescaler:
  - cnt counts 0..2^SCAN_DIV_LOG2-1 and wraps.
  - A wrap ends the slot: idx increments and wraps NUM_DIGITS-1 -> 0.
  - idx wrap = frame boundary.
- Frame_Done: registered; high exactly one cycle, the cycle after idx wraps to 0.
- Double buffering:
  - Load=1 writes pending, sets pending_valid. Last Load wins.
  - At a frame boundary with pending_valid=1: display<=pending, pending_valid<=0.
  - Load in the same cycle as a frame boundary: display takes that cycle's Load data directly; pending_valid ends 0.
  - Display contents never change mid-frame.
- Blanking (digit d):
  - Blanked if Digit_En[d]=0.
  - Also blanked if Blank_Lz=1, nibble d = 0, and all more-significant nibbles = 0.
  - Digit 0 is never leading-zero blanked.
  - A blanked digit gives An all 1 and Cathodes 8'hFF for its whole slot.
- Anode on for idx when all hold:
  - digit not blanked;
  - cnt >= GUARD;
  - cnt[SCAN_DIV_LOG2-1 -: BRIGHT_BITS] <= Brightness.
- Cathodes:
  - Segment decode is the standard hex table: 0->0000001, 1->1001111, ... F->0111000 (abcdefg, active-low).
  - Dp bit = ~Dp_display[idx].
  - Cathodes forced to 8'hFF whenever An is all 1.
- Latency: An, Cathodes and Scan_Idx are registered and reflect the cnt/idx of the previous cycle (1-cycle latency).
- Arithmetic: all counters unsigned; no saturation. Non-power-of-two NUM_DIGITS wraps explicitly at NUM_DIGITS-1.

Decomposition:
- Shared package ssd_pkg holds:
  - the hex-to-segment constant table (16 x 7 bits, active-low);
  - BLANK_CATHODES = 8'hFF;
  - a clog2 function.
- One sub-module, ssd_hex_decode: combinational 4-bit nibble + dp -> 8-bit cathode pattern, also reusable by other display blocks.

Test Plan:
All scenarios use NUM_DIGITS=4, SCAN_DIV_LOG2=4, BRIGHT_BITS=2, GUARD=2 (16-cycle slot, 64-cycle frame).
1. Release reset, Load=1 with Digits_In=16'h1234 at cycle 5, Brightness=3, Digit_En=4'hF -> display stays 0 for cycles 0..63. In slot 0 of frame 2: An=4'b1110 for cnt 2..15 (+1 latency), Cathodes=8'b10011001 ("4"). Frame_Done pulses once per 64 cycles.
2. Brightness=2'b01, Digits=16'h8888 -> each slot's anode low only for cnt 2..7 (6 cycles), Cathodes=8'hFF for the remaining cycles.
3. Blank_Lz=1, Digits=16'h0050 -> digits 3 and 2 stay An-high and 8'hFF; digit 1 shows "5" (01001001); digit 0 shows "0". With Digits=16'h0000, only digit 0 lights.
4. Load 16'hAAAA then 16'hBBBB within one frame -> the next frame shows B on all digits. A Load coinciding with the frame-boundary cycle is displayed in the frame that starts there.
5. Digit_En=4'b0101 with Dp_In=4'b0001 -> digits 1 and 3 are fully dark; digit 0 Cathodes LSB=0.
6. Reset=0 at slot 2 cnt 9 -> next cycle An=4'hF, Cathodes=8'hFF, Scan_Idx=0, display=0. After release, scanning restarts at slot 0 cnt 0 with no Frame_Done until 64 cycles later.
